// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

  // Scheduler FSM encoding, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ISSUE       = 2'd1;
  localparam logic [1:0] ST_WAIT_ACTIVE = 2'd2;
  localparam logic [1:0] ST_WAIT_FINISH = 2'd3;

  typedef logic [1:0] state_t;

  // 115200 baud from a 50 MHz clock.
  localparam int CLKS_PER_BIT = 434;

  // One 10-bit frame is 4340 clocks at CLKS_PER_BIT; 4800 leaves some slack.
  localparam logic [12:0] TIMEOUT_CYCLES_DFLT = 13'd4800;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Producer-side and transmitter-side handshake bundle of the TX scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_valid is held by a producer until its req_ready pulse.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_done;
  logic                 tx_data_request;
  logic [7:0]           tx_data;
  logic                 tx_active;
  logic                 tx_finish;
  logic                 busy;
  logic [ID_W-1:0]      owner;
  logic                 timeout_err;

  // The scheduler side.
  modport master (
    input  req_valid, req_data, tx_active, tx_finish,
    output req_ready, req_done, tx_data_request, tx_data, busy, owner, timeout_err
  );

  // Producers plus the serializer.
  modport slave (
    output req_valid, req_data, tx_active, tx_finish,
    input  req_ready, req_done, tx_data_request, tx_data, busy, owner, timeout_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request above last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any_grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] cand;

  // Scan last_grant+1 .. last_grant+NUM_REQ, keep the first hit.
  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART serializer between NUM_REQ byte producers, round-robin.
// Latency: grant 1 clk after req_valid in IDLE; next start 2 clks after tx_finish.
// Backpressure: producers hold req_valid until req_ready; one byte in flight at a time.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int              NUM_REQ        = 4,
  parameter int              ID_W           = 2,
  parameter int              TMO_W          = 13,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.master  bus
);

  // Counter value on the last allowed waiting cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYCLES - 1'b1;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               any_grant;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [7:0]         req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = bus.req_data[8*g +: 8];
  end

  assign grant_onehot = NUM_REQ'(1) << grant_idx;
  assign owner_onehot = NUM_REQ'(1) << bus.owner;

  // Arbitration only matters in IDLE; last_grant moves on completion or abort.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .any_grant  (any_grant),
    .grant_idx  (grant_idx)
  );

  // Scheduler FSM; all pulses default low and are raised for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      last_grant          <= ID_W'(NUM_REQ - 1);
      tmo_cnt             <= '0;
      bus.req_ready       <= '0;
      bus.req_done        <= '0;
      bus.tx_data_request <= 1'b0;
      bus.tx_data         <= '0;
      bus.busy            <= 1'b0;
      bus.owner           <= '0;
      bus.timeout_err     <= 1'b0;
    end else begin
      bus.req_ready       <= '0;
      bus.req_done        <= '0;
      bus.tx_data_request <= 1'b0;
      bus.timeout_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_grant) begin
            bus.tx_data         <= req_byte[grant_idx];
            bus.owner           <= grant_idx;
            bus.req_ready       <= grant_onehot;
            bus.tx_data_request <= 1'b1;
            bus.busy            <= 1'b1;
            state               <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Start pulse is visible this cycle; TX status is not trusted yet.
          tmo_cnt <= '0;
          state   <= ST_WAIT_ACTIVE;
        end
        ST_WAIT_ACTIVE, ST_WAIT_FINISH: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Finish outranks expiry; a finish without active still completes.
          if (bus.tx_finish) begin
            bus.req_done <= owner_onehot;
            last_grant   <= bus.owner;
            bus.busy     <= 1'b0;
            state        <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.timeout_err <= 1'b1;
            last_grant      <= bus.owner;
            bus.busy        <= 1'b0;
            state           <= ST_IDLE;
          end else if (state == ST_WAIT_ACTIVE && bus.tx_active) begin
            state <= ST_WAIT_FINISH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: random bytes, event scoreboard, behavioural TX.
// Latency: n/a.
// Backpressure: producers hold req_valid until their req_ready pulse.
module tb_uart_tx_scheduler;
  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int TMO   = 100;
  localparam int FRAME = 40;   // 4 clocks per bit, 10 bits

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_scheduler_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ        (N),
    .ID_W           (IDW),
    .TMO_W          (13),
    .TIMEOUT_CYCLES (13'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Free-running cycle index, read on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serializer: active 1 clk after the start pulse, finish at frame end.
  int frame_len = FRAME;
  bit hang      = 1'b0;
  bit no_active = 1'b0;
  int tx_cnt    = -1;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      tx_cnt        = -1;
      bus.tx_active = 1'b0;
      bus.tx_finish = 1'b0;
    end else begin
      bus.tx_finish = 1'b0;
      if (bus.tx_data_request) begin
        tx_cnt = 0;
      end else if (tx_cnt >= 0) begin
        tx_cnt++;
        if (tx_cnt == 1 && !no_active) bus.tx_active = 1'b1;
        if (tx_cnt == frame_len && !hang) begin
          bus.tx_finish = 1'b1;
          bus.tx_active = 1'b0;
          tx_cnt        = -1;
        end
      end
    end
  end

  // Scoreboard state
  logic [7:0]   bytes [N];
  int           reassert_left [N];
  int           model_lg        = N - 1;
  int           in_flight       = -1;
  int           issue_cyc       = 0;
  int           fin_cyc         = -1000;
  int           end_cyc         = -1000;
  bit           end_pending     = 1'b0;
  int           first_grant_cyc = -1;
  int           last_kind       = 0;   // 1 = done, 2 = timeout
  int           set_cyc         = 0;
  logic [N-1:0] prev_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int lg);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (lg + k) % N;
      if (v[c[IDW-1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int k = 0; k < N; k++) bus.req_data[8*k +: 8] = bytes[k];
  endtask

  // Advance clocks, checking every grant / done / timeout event against the model.
  task automatic run(input int n_ev, input int budget, input bit fixed);
    int ev;
    ev = 0;
    prev_valid = bus.req_valid;
    for (int t = 0; t < budget && (fixed || ev < n_ev); t++) begin
      @(negedge clk);
      if (bus.tx_finish) fin_cyc = cyc;
      if (bus.req_ready != '0) begin
        int w;
        logic [IDW-1:0] wi;
        w  = rr_pick(prev_valid, model_lg);
        wi = w[IDW-1:0];
        chk("grant_vec", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
          chk("grant_start_pulse", 32'(bus.tx_data_request), 32'd1);
          chk("grant_tx_data", 32'(bus.tx_data), 32'(bytes[wi]));
          chk("grant_owner", 32'(bus.owner), 32'(w));
          chk("grant_busy", 32'(bus.busy), 32'd1);
          if (end_pending) chk("grant_gap", 32'(cyc - end_cyc), 32'd1);
          if (first_grant_cyc < 0) first_grant_cyc = cyc;
          in_flight = w;
          issue_cyc = cyc;
          if (reassert_left[wi] > 0) begin
            reassert_left[wi]--;
            bytes[wi] = 8'($urandom);
            drive_data();
          end else begin
            bus.req_valid[wi] = 1'b0;
          end
        end
        end_pending = 1'b0;
      end
      if (bus.req_done != '0) begin
        chk("done_vec", 32'(bus.req_done), (in_flight < 0) ? 32'd0 : (32'd1 << in_flight));
        chk("done_latency", 32'(cyc - fin_cyc), 32'd1);
        chk("done_no_tmo", 32'(bus.timeout_err), 32'd0);
        if (in_flight >= 0) model_lg = in_flight;
        in_flight   = -1;
        end_cyc     = cyc;
        end_pending = (bus.req_valid != '0);
        last_kind   = 1;
        ev++;
      end else if (bus.timeout_err) begin
        chk("tmo_latency", 32'(cyc - issue_cyc), 32'(TMO + 1));
        if (in_flight >= 0) model_lg = in_flight;
        in_flight   = -1;
        end_cyc     = cyc;
        end_pending = (bus.req_valid != '0);
        last_kind   = 2;
        ev++;
      end
      prev_valid = bus.req_valid;
    end
    chk("event_count", 32'(ev), 32'(n_ev));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},   32'(bus.req_ready), 32'd0);
    chk({tag, "_done"},    32'(bus.req_done), 32'd0);
    chk({tag, "_start"},   32'(bus.tx_data_request), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_owner"},   32'(bus.owner), 32'd0);
    chk({tag, "_tmo"},     32'(bus.timeout_err), 32'd0);
  endtask

  task automatic rand_bytes();
    for (int k = 0; k < N; k++) bytes[k] = 8'($urandom);
    drive_data();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int k = 0; k < N; k++) begin
      bytes[k]         = 8'h00;
      reassert_left[k] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 0
    bytes[0] = 8'hA5;
    drive_data();
    bus.req_valid   = 4'b0001;
    set_cyc         = cyc;
    first_grant_cyc = -1;
    run(1, 200, 1'b0);
    chk("single_ready_latency", 32'(first_grant_cyc - set_cyc), 32'd1);
    chk("single_busy_after", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("single_idle_later", 32'(bus.busy), 32'd0);

    // Fairness: all four keep requesting
    rand_bytes();
    for (int k = 0; k < N; k++) reassert_left[k] = 10;
    bus.req_valid = 4'b1111;
    run(5, 400, 1'b0);
    for (int k = 0; k < N; k++) reassert_left[k] = 0;
    run($countones(bus.req_valid), 400, 1'b0);

    // Back-to-back: requester 2 re-asserts right after its ready
    rand_bytes();
    reassert_left[2] = 1;
    bus.req_valid    = 4'b1111;
    run(5, 400, 1'b0);

    // Frame where the serializer never reports active
    no_active     = 1'b1;
    bytes[1]      = 8'($urandom);
    drive_data();
    bus.req_valid = 4'b0010;
    run(1, 200, 1'b0);
    chk("no_active_kind", 32'(last_kind), 32'd1);
    no_active = 1'b0;

    // Stuck serializer: abort, then the other pending requester proceeds
    hang = 1'b1;
    rand_bytes();
    bus.req_valid = 4'b0011;
    run(1, 300, 1'b0);
    chk("hang_kind", 32'(last_kind), 32'd2);
    hang = 1'b0;
    run(1, 200, 1'b0);
    chk("after_tmo_kind", 32'(last_kind), 32'd1);

    // Finish on the expiry cycle wins; one cycle later it is an abort
    frame_len = TMO;
    rand_bytes();
    bus.req_valid = 4'b0100;
    run(1, 300, 1'b0);
    chk("edge_finish_kind", 32'(last_kind), 32'd1);
    frame_len = TMO + 1;
    bus.req_valid = 4'b1000;
    run(1, 300, 1'b0);
    chk("late_finish_kind", 32'(last_kind), 32'd2);
    frame_len = FRAME;
    repeat (3) @(negedge clk);

    // Reset mid-frame: serve 0, start 0 again, reset while waiting for finish
    rand_bytes();
    bus.req_valid = 4'b0001;
    run(1, 200, 1'b0);
    bus.req_valid = 4'b0001;
    run(0, 20, 1'b1);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    rand_bytes();
    bus.req_valid = 4'b0011;
    @(negedge clk);
    rst         = 1'b0;
    model_lg    = N - 1;
    in_flight   = -1;
    end_pending = 1'b0;
    first_grant_cyc = -1;
    run(2, 300, 1'b0);
    chk("post_reset_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
